// File: rtl/button_pulse_array.sv
// ---------------------------------------------------------------------------
// button_pulse_array
//
// Multi-channel debounced one-shot generator for the combination-lock front
// end. Every raw input is registered once and then debounced by its own
// four-state machine. Each channel drives a clean registered level and a
// registered single-cycle pulse on the selected edge(s).
//
// Optional feature macro: PULSE_REPEAT_EN
//   When defined, a channel that stays pressed produces extra auto-repeat
//   pulses. The first comes HOLD cycles after the press pulse, and the rest
//   follow every RATE cycles. Repeat pulses exist only for EDGE 0 or 2.
//   When undefined, no repeat logic is built and HOLD/RATE only size the
//   shared counter.
//
// Parameters:
//   WIDTH     number of independent channels
//   DEBOUNCE  consecutive stable samples needed to accept a change (2..255)
//   EDGE      0 = press pulse, 1 = release pulse, 2 = both
//   HOLD      cycles from the press pulse to the first repeat pulse (>= 2)
//   RATE      cycles between later repeat pulses (>= 2)
//
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   synchronous active-high reset
//   In     in   [WIDTH] raw inputs, may be asynchronous to Clock
//   Level  out  [WIDTH] debounced level, registered
//   Pulse  out  [WIDTH] one-cycle pulse, registered
// ---------------------------------------------------------------------------
module button_pulse_array #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 4,
    parameter int EDGE     = 0,
    parameter int HOLD     = 16,
    parameter int RATE     = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    output logic [WIDTH-1:0] Level,
    output logic [WIDTH-1:0] Pulse
);

    localparam int MAX_DH  = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
    localparam int MAX_ALL = (MAX_DH > RATE) ? MAX_DH : RATE;
    localparam int CW      = $clog2(MAX_ALL + 32'sd1);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 32'sd1);

    localparam logic PRESS_EDGE = (EDGE == 32'sd0) || (EDGE == 32'sd2);
    localparam logic REL_EDGE   = (EDGE == 32'sd1) || (EDGE == 32'sd2);

`ifdef PULSE_REPEAT_EN
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
    localparam logic [CW-1:0] RATE_C = CW'(RATE);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEB_HI  = 2'd1,
        PRESSED = 2'd2,
        DEB_LO  = 2'd3
    } state_t;

    logic [WIDTH-1:0] s_r;
    logic [WIDTH-1:0] level_r;
    logic [WIDTH-1:0] pulse_r;
    logic [WIDTH-1:0] level_nxt_s;
    logic [WIDTH-1:0] pulse_nxt_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t        state_r;
        state_t        state_nxt_s;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_nxt_s;
        logic          repeat_hit_s;
        logic          ch_level_s;
        logic          ch_pulse_s;
        logic          press_s;
        logic          release_s;
`ifdef PULSE_REPEAT_EN
        // phase_r is 0 while waiting out HOLD and 1 once RATE spacing applies.
        logic          phase_r;
        logic          phase_nxt_s;

        // A repeat fires only if the channel is still held on this edge.
        assign repeat_hit_s = PRESS_EDGE && (state_r == PRESSED) && s_r[i] &&
                              (cnt_r == (phase_r ? RATE_C : HOLD_C));
`else
        assign repeat_hit_s = 1'b0;
`endif

        // Channel state register.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                state_r <= IDLE;
                cnt_r   <= CNT_ZERO;
`ifdef PULSE_REPEAT_EN
                phase_r <= 1'b0;
`endif
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
`ifdef PULSE_REPEAT_EN
                phase_r <= phase_nxt_s;
`endif
            end
        end

        // Next-state and counter logic.
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
`ifdef PULSE_REPEAT_EN
            phase_nxt_s = phase_r;
`endif
            case (state_r)
                IDLE: begin
                    if (s_r[i]) begin
                        state_nxt_s = DEB_HI;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                DEB_HI: begin
                    if (!s_r[i]) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == DEB_LAST) begin
                        // Counter restarts here so it doubles as the repeat timer.
                        state_nxt_s = PRESSED;
                        cnt_nxt_s   = CNT_ZERO;
`ifdef PULSE_REPEAT_EN
                        phase_nxt_s = 1'b0;
`endif
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s_r[i]) begin
                        state_nxt_s = DEB_LO;
                        cnt_nxt_s   = CNT_ONE;
`ifdef PULSE_REPEAT_EN
                        phase_nxt_s = 1'b0;
`endif
                    end else begin
`ifdef PULSE_REPEAT_EN
                        if (repeat_hit_s) begin
                            // Reload to 1 so the next hit lands RATE edges later.
                            cnt_nxt_s   = CNT_ONE;
                            phase_nxt_s = 1'b1;
                        end else if (PRESS_EDGE) begin
                            cnt_nxt_s   = cnt_r + CNT_ONE;
                        end else begin
                            cnt_nxt_s   = cnt_r;
                        end
`else
                        cnt_nxt_s   = cnt_r;
`endif
                    end
                end
                DEB_LO: begin
                    if (s_r[i]) begin
                        // Bounce back: no pulse, and repeat timing restarts.
                        state_nxt_s = PRESSED;
                        cnt_nxt_s   = CNT_ZERO;
`ifdef PULSE_REPEAT_EN
                        phase_nxt_s = 1'b0;
`endif
                    end else if (cnt_r == DEB_LAST) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end

        // Output decode. level_r still holds the pre-transition level, so
        // PRESSED with level 0 is exactly the DEB_HI->PRESSED entry, and IDLE
        // with level 1 is exactly the DEB_LO->IDLE exit.
        always_comb begin
            press_s    = (state_r == PRESSED) && !level_r[i];
            release_s  = (state_r == IDLE) && level_r[i];
            ch_level_s = (state_r == PRESSED) || (state_r == DEB_LO);
            ch_pulse_s = (PRESS_EDGE && press_s) || (REL_EDGE && release_s) ||
                         repeat_hit_s;
        end

        assign level_nxt_s[i] = ch_level_s;
        assign pulse_nxt_s[i] = ch_pulse_s;
    end

    // Input sampling flop and registered outputs for all channels.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s_r     <= {WIDTH{1'b0}};
            level_r <= {WIDTH{1'b0}};
            pulse_r <= {WIDTH{1'b0}};
        end else begin
            s_r     <= In;
            level_r <= level_nxt_s;
            pulse_r <= pulse_nxt_s;
        end
    end

    assign Level = level_r;
    assign Pulse = pulse_r;

endmodule
